// File: rtl/data_sram_responder.sv
// Data-side SRAM-like slave: in-order request queue in front of a word-addressed
// RAM, answering each accepted request with one data_ok pulse after RESP_LAT.
module data_sram_responder #(
  parameter int unsigned MEM_AW   = 12,
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned RESP_LAT = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned LW = $clog2(RESP_LAT + 1);

  logic              resetn_q;
  logic [CW-1:0]     count;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [LW-1:0]     lat_cnt;
  logic              data_ok_q;
  logic [31:0]       rdata_q;

  logic              q_wr    [DEPTH];
  logic [3:0]        q_wstrb [DEPTH];
  logic [MEM_AW-1:0] q_word  [DEPTH];
  logic [31:0]       q_wdata [DEPTH];

  logic [31:0]       ram [2**MEM_AW];

  logic              full;
  logic              accept;
  logic              bypass;
  logic              push;
  logic              pop_q;
  logic              pop_now;
  logic              h_wr;
  logic [3:0]        h_wstrb;
  logic [MEM_AW-1:0] h_word;
  logic [31:0]       h_wdata;

  // Size and the byte-offset / upper address bits are carried but never decoded.
  logic unused_bits;
  assign unused_bits = ^{data_sram_size, data_sram_addr[1:0], data_sram_addr[31:MEM_AW+2]};

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full              = (count == CW'(DEPTH));
  assign data_sram_addr_ok = resetn && resetn_q && !full;
  assign accept            = data_sram_req && data_sram_addr_ok;
  // With a one-cycle latency an accept into an empty queue is answered at the
  // accept edge itself, so it skips the queue storage entirely.
  assign bypass            = accept && (count == '0) && (RESP_LAT == 1);
  assign push              = accept && !bypass;
  assign pop_q             = (count != '0) && (lat_cnt == LW'(RESP_LAT - 1));
  assign pop_now           = pop_q || bypass;

  assign data_sram_data_ok = resetn && data_ok_q;
  assign data_sram_rdata   = resetn ? rdata_q : '0;

  // Select the request being serviced: queue head, or the incoming request on bypass.
  always_comb begin
    h_wr    = q_wr[rd_ptr];
    h_wstrb = q_wstrb[rd_ptr];
    h_word  = q_word[rd_ptr];
    h_wdata = q_wdata[rd_ptr];
    if (count == '0) begin
      h_wr    = data_sram_wr;
      h_wstrb = data_sram_wstrb;
      h_word  = data_sram_addr[MEM_AW+1:2];
      h_wdata = data_sram_wdata;
    end
  end

  // Queue payload storage, written at the tail on every push.
  always_ff @(posedge clk) begin
    if (push) begin
      q_wr[wr_ptr]    <= data_sram_wr;
      q_wstrb[wr_ptr] <= data_sram_wstrb;
      q_word[wr_ptr]  <= data_sram_addr[MEM_AW+1:2];
      q_wdata[wr_ptr] <= data_sram_wdata;
    end
  end

  // Byte-masked RAM write at the pop edge of a write request.
  always_ff @(posedge clk) begin
    if (resetn && pop_now && h_wr) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (h_wstrb[i]) ram[h_word][8*i +: 8] <= h_wdata[8*i +: 8];
      end
    end
  end

  // Queue bookkeeping, head residency counter and registered response.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      resetn_q  <= 1'b0;
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      lat_cnt   <= '0;
      data_ok_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      resetn_q <= 1'b1;
      if (push)  wr_ptr <= ptr_next(wr_ptr);
      if (pop_q) rd_ptr <= ptr_next(rd_ptr);
      count <= count + CW'(push) - CW'(pop_q);
      // The accept cycle counts as the first resident cycle of a fresh head;
      // a head promoted by a pop starts counting after the pop edge.
      if (pop_now)            lat_cnt <= '0;
      else if (count != '0)   lat_cnt <= lat_cnt + 1'b1;
      else if (push)          lat_cnt <= LW'(1);
      else                    lat_cnt <= '0;
      data_ok_q <= pop_now;
      if (pop_now) rdata_q <= h_wr ? '0 : ram[h_word];
    end
  end

endmodule

// File: tb/tb_data_sram_responder.sv
// Scoreboard bench for data_sram_responder: one instance at RESP_LAT=1 and one
// at RESP_LAT=4, sharing request fields; expected responses are queued at issue.
module tb_data_sram_responder;

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic        sel;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        req_a, req_b;
  logic        ok_a, ok_b, dok_a, dok_b;
  logic [31:0] rd_a, rd_b;

  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  int   last_a = -1000;
  int   last_b = -1000;
  exp_t qa[$];
  exp_t qb[$];

  assign req_a = req & ~sel;
  assign req_b = req & sel;

  always #5 clk = ~clk;

  data_sram_responder #(.MEM_AW(12), .DEPTH(2), .RESP_LAT(1)) dut_l1 (
    .clk(clk), .resetn(resetn), .data_sram_req(req_a), .data_sram_wr(wr),
    .data_sram_size(size), .data_sram_wstrb(wstrb), .data_sram_addr(addr),
    .data_sram_wdata(wdata), .data_sram_addr_ok(ok_a), .data_sram_data_ok(dok_a),
    .data_sram_rdata(rd_a)
  );

  data_sram_responder #(.MEM_AW(12), .DEPTH(2), .RESP_LAT(4)) dut_l4 (
    .clk(clk), .resetn(resetn), .data_sram_req(req_b), .data_sram_wr(wr),
    .data_sram_size(size), .data_sram_wstrb(wstrb), .data_sram_addr(addr),
    .data_sram_wdata(wdata), .data_sram_addr_ok(ok_b), .data_sram_data_ok(dok_b),
    .data_sram_rdata(rd_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor one DUT: pop the head expectation on data_ok, flag stray or missing pulses.
  task automatic mon(input bit b, input logic dok, input logic [31:0] rd);
    exp_t h;
    bit   have;
    have = b ? (qb.size() > 0) : (qa.size() > 0);
    if (have) h = b ? qb[0] : qa[0];
    if (dok === 1'b1) begin
      if (!have) begin
        checks++;
        errors++;
        $display("FAIL unexpected_data_ok dut%0d: data_ok at cycle %0d, none expected", b, cyc);
      end else begin
        if (b) void'(qb.pop_front()); else void'(qa.pop_front());
        chk($sformatf("resp_cycle dut%0d", b), cyc, h.cyc);
        chk($sformatf("resp_rdata dut%0d", b), rd, h.data);
      end
    end else if (dok !== 1'b0 || (have && cyc > h.cyc)) begin
      checks++;
      errors++;
      $display("FAIL missing_data_ok dut%0d: data_ok=%b at cycle %0d, expected pulse at %0d",
               b, dok, cyc, h.cyc);
      if (have) begin
        if (b) void'(qb.pop_front()); else void'(qa.pop_front());
      end
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    #2;
    mon(1'b0, dok_a, rd_a);
    mon(1'b1, dok_b, rd_b);
  end

  // Present one request (called just after a negedge) and hold it until accepted.
  // For reads, val is the hand-computed expected rdata; for writes, the wdata.
  task automatic issue(input bit b, input logic w, input logic [3:0] st,
                       input logic [31:0] ad, input logic [31:0] val);
    bit   done = 1'b0;
    int   a_edge;
    exp_t x;
    sel = b; req = 1'b1; wr = w; wstrb = st; addr = ad; wdata = w ? val : 32'h0;
    size = 2'd2;
    for (int i = 0; i < 100 && !done; i++) begin
      #1;
      if ((b ? ok_b : ok_a) === 1'b1) begin
        a_edge = cyc + 1;
        x.data = w ? 32'h0 : val;
        if (b) begin
          x.cyc  = (a_edge + 3 > last_b + 4) ? a_edge + 3 : last_b + 4;
          last_b = x.cyc;
          qb.push_back(x);
        end else begin
          x.cyc  = (a_edge > last_a + 1) ? a_edge : last_a + 1;
          last_a = x.cyc;
          qa.push_back(x);
        end
        done = 1'b1;
      end
      @(negedge clk);
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout dut%0d: addr_ok not seen for addr %h, required 1", b, ad);
    end
  endtask

  task automatic drain();
    int n = 0;
    req = 1'b0;
    while ((qa.size() > 0 || qb.size() > 0) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (qa.size() > 0 || qb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d/%0d responses outstanding, required 0/0",
               qa.size(), qb.size());
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    resetn = 1'b0; sel = 1'b0; req = 1'b1; wr = 1'b0; size = 2'd2;
    wstrb = 4'h0; addr = 32'h0; wdata = 32'h0;

    // Reset held with req high: every output low.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_flags", {28'h0, ok_a, ok_b, dok_a, dok_b}, 32'h0);
      chk("reset_rdata", rd_a | rd_b, 32'h0);
    end
    resetn = 1'b1; req = 1'b0;
    #1 chk("release_addr_ok_low", {30'h0, ok_a, ok_b}, 32'h0);
    @(negedge clk);
    chk("release_addr_ok_high", {30'h0, ok_a, ok_b}, 32'h3);

    // Write then read, latency 1.
    issue(1'b0, 1'b1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF);
    issue(1'b0, 1'b0, 4'h0, 32'h0000_0010, 32'hDEAD_BEEF);
    drain();

    // Partial strobe, then a zero-strobe write that must not alter the word.
    issue(1'b0, 1'b1, 4'b0010, 32'h0000_0010, 32'h1122_3344);
    issue(1'b0, 1'b0, 4'h0,    32'h0000_0010, 32'hDEAD_33EF);
    issue(1'b0, 1'b1, 4'b0000, 32'h0000_0010, 32'hFFFF_FFFF);
    issue(1'b0, 1'b0, 4'h0,    32'h0000_0010, 32'hDEAD_33EF);
    drain();

    // Aliasing: 0x4010 and 0x0010 share a word; back-to-back write then read.
    issue(1'b0, 1'b1, 4'hF, 32'h0000_4010, 32'h1357_9BDF);
    issue(1'b0, 1'b0, 4'h0, 32'h0000_0010, 32'h1357_9BDF);
    drain();

    // Backpressure at latency 4, depth 2: five requests with req held high.
    issue(1'b1, 1'b1, 4'hF,    32'h0000_0040, 32'h0102_0304);
    issue(1'b1, 1'b0, 4'h0,    32'h0000_0040, 32'h0102_0304);
    #1 chk("full_addr_ok_low", {31'h0, ok_b}, 32'h0);
    issue(1'b1, 1'b1, 4'b1100, 32'h0000_0040, 32'hAABB_CCDD);
    issue(1'b1, 1'b0, 4'h0,    32'h0000_0040, 32'hAABB_0304);
    issue(1'b1, 1'b0, 4'h0,    32'h0000_0040, 32'hAABB_0304);
    drain();

    // Reset with a write and a read still queued: both dropped, RAM untouched.
    issue(1'b1, 1'b1, 4'hF, 32'h0000_0020, 32'hA5A5_A5A5);
    drain();
    issue(1'b1, 1'b1, 4'hF, 32'h0000_0020, 32'h5A5A_5A5A);
    issue(1'b1, 1'b0, 4'h0, 32'h0000_0020, 32'h5A5A_5A5A);
    req = 1'b0; resetn = 1'b0;
    qb.delete();
    last_b = -1000;
    @(negedge clk);
    resetn = 1'b1;
    repeat (8) @(negedge clk);
    issue(1'b1, 1'b0, 4'h0, 32'h0000_0020, 32'hA5A5_A5A5);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule
